// File: rtl/mod3_frame_tx.sv
// Serial frame transmitter: shifts a DW-bit word out MSB-first, then appends a
// 2-bit check field so every frame, read as a binary number, is divisible by 3.
module mod3_frame_tx #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic          dout,
  output logic          dout_vld,
  output logic          dout_first,
  output logic          dout_last,
  output logic          busy
);

  // state  | meaning
  // S_IDLE | no frame on the line, ready to accept a word
  // S_DATA | dout carries a data bit; cnt = data bits still to follow
  // S_CHK0 | dout carries c[1]
  // S_CHK1 | dout carries c[0] (frame end)

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CHK0 = 2'd2,
    S_CHK1 = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] sreg, sreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    res, res_nxt;
  logic          c0, c0_nxt;
  logic          dout_nxt, vld_nxt, first_nxt, last_nxt;
  logic          accept;

  // (2*r + b) mod 3 without a divider; r is always 0..2 so one subtract suffices
  function automatic logic [1:0] res_step(input logic [1:0] r, input logic b);
    logic [2:0] s;
    s = {r, 1'b0} + {2'b00, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign din_rdy = (state == S_IDLE) & ~rst;
  assign accept  = din_vld & din_rdy;
  assign busy    = dout_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      res        <= '0;
      c0         <= 1'b0;
      dout       <= 1'b0;
      dout_vld   <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      cnt        <= cnt_nxt;
      res        <= res_nxt;
      c0         <= c0_nxt;
      dout       <= dout_nxt;
      dout_vld   <= vld_nxt;
      dout_first <= first_nxt;
      dout_last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_DATA;
      S_DATA:  if (cnt == '0) state_nxt = S_CHK0;
      S_CHK0:  state_nxt = S_CHK1;
      S_CHK1:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output registers hold the bit currently on the line, so the values
  // computed here are what appears on dout after the next edge.
  always_comb begin
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    res_nxt   = res;
    c0_nxt    = c0;
    dout_nxt  = 1'b0;
    vld_nxt   = 1'b0;
    first_nxt = 1'b0;
    last_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          sreg_nxt  = {din[DW-2:0], 1'b0};
          cnt_nxt   = CW'(DW - 1);
          res_nxt   = res_step(2'd0, din[DW-1]);
          dout_nxt  = din[DW-1];
          vld_nxt   = 1'b1;
          first_nxt = 1'b1;
        end
      end
      S_DATA: begin
        vld_nxt = 1'b1;
        if (cnt != '0) begin
          dout_nxt = sreg[DW-1];
          sreg_nxt = {sreg[DW-2:0], 1'b0};
          res_nxt  = res_step(res, sreg[DW-1]);
          cnt_nxt  = cnt - CW'(1);
        end else begin
          // c = (3 - res) mod 3 maps 0->00, 1->10, 2->01: the residue bits swapped
          dout_nxt = res[0];
          c0_nxt   = res[1];
        end
      end
      S_CHK0: begin
        dout_nxt = c0;
        vld_nxt  = 1'b1;
        last_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Bench for mod3_frame_tx: directed frame table, reset abort, and a random
// regression checked cycle-by-cycle against an arithmetic frame model.
module tb_mod3_frame_tx;

  localparam int DW = 8;
  localparam int FW = DW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_vld;
  logic          din_rdy, dout, dout_vld, dout_first, dout_last, busy;

  mod3_frame_tx #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_first(dout_first),
    .dout_last(dout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is din*4 + (3 - din mod 3) mod 3, sent MSB-first.
  // pos is the index of the bit on the line (-1 = idle).
  int            pos = -1;
  logic [FW-1:0] exp_frame = '0;
  int            n_acc = 0;
  bit            started = 0;

  function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] w);
    longint c;
    c = (3 - (longint'(w) % 3)) % 3;
    return FW'(longint'(w) * 4 + c);
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) pos <= -1;
    else if (pos < 0) begin
      if (din_vld) begin
        exp_frame <= frame_of(din);
        pos       <= 0;
        n_acc     <= n_acc + 1;
      end
    end else if (pos == FW - 1) pos <= -1;
    else pos <= pos + 1;
  end

  // Line monitor: compares every output each cycle and plays the downstream
  // checker (stream residue over all dout bits since reset).
  logic [FW-1:0] obs = '0;
  logic [FW-1:0] last_frame = '0;
  int            nbits = 0;
  int            sres = 0;
  int            frames_done = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("din_rdy", din_rdy, (!rst && pos < 0));
      chk("dout_vld", dout_vld, (pos >= 0));
      chk("dout", dout, (pos >= 0) ? exp_frame[FW-1-pos] : 1'b0);
      chk("dout_first", dout_first, (pos == 0));
      chk("dout_last", dout_last, (pos == FW - 1));
      chk("busy", busy, (pos >= 0));
      if (rst) begin
        nbits <= 0;
        sres  <= 0;
      end else begin
        sres <= (2 * sres + int'(dout)) % 3;
        if (dout_last) begin
          chk("frame_len", nbits + 1, FW);
          chk("flag_y", (2 * sres + int'(dout)) % 3, 0);
          last_frame  <= {obs[FW-2:0], dout};
          frames_done <= frames_done + 1;
          nbits       <= 0;
        end else if (dout_vld) begin
          obs   <= {obs[FW-2:0], dout};
          nbits <= nbits + 1;
        end
      end
    end
  end

  typedef struct {
    logic [DW-1:0] w;
    bit            keep;
    logic [FW-1:0] frame;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    int t;
    int target;
    din     = tbl[i].w;
    din_vld = 1'b1;
    t = 0;
    while (!din_rdy && t < 100) begin step(); t++; end
    chk("rdy_timeout", (t < 100), 1);
    step();
    target = frames_done + 1;
    if (tbl[i].keep && i + 1 < 6) din = tbl[i + 1].w;
    else begin
      din_vld = 1'b0;
      din     = DW'($urandom);
    end
    t = 0;
    while (frames_done < target && t < 100) begin step(); t++; end
    chk("frame_timeout", (t < 100), 1);
    chk($sformatf("frame_%02h", tbl[i].w), last_frame, tbl[i].frame);
  endtask

  initial begin
    int f0, a0, cyc;
    tbl[0] = '{8'h00, 1'b0, 10'b0000000000};
    tbl[1] = '{8'h01, 1'b0, 10'b0000000110};
    tbl[2] = '{8'h05, 1'b1, 10'b0000010101};
    tbl[3] = '{8'hFF, 1'b0, 10'b1111111100};
    tbl[4] = '{8'hA5, 1'b0, 10'b1010010100};
    tbl[5] = '{8'h02, 1'b0, 10'b0000001001};

    rst = 1'b1; din = '0; din_vld = 1'b0;
    step(); step();
    chk("reset_dout_vld", dout_vld, 0);
    chk("reset_rdy", din_rdy, 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_reset", din_rdy, 1);

    for (int i = 0; i < 5; i++) run_vec(i);

    // idle gap after A5: nothing may be accepted
    f0 = frames_done;
    a0 = n_acc;
    repeat (5) step();
    chk("gap_no_frame", frames_done, f0);
    chk("gap_no_accept", n_acc, a0);

    // reset on the 4th data bit of 3C aborts the frame
    din = 8'h3C; din_vld = 1'b1;
    cyc = 0;
    while (!din_rdy && cyc < 100) begin step(); cyc++; end
    step();
    din_vld = 1'b0;
    repeat (3) step();
    chk("abort_bit4_vld", dout_vld, 1);
    rst = 1'b1;
    step();
    chk("abort_dout", dout, 0);
    chk("abort_vld", dout_vld, 0);
    chk("abort_last", dout_last, 0);
    chk("abort_rdy", din_rdy, 0);
    rst = 1'b0;
    #1;
    chk("abort_rdy_release", din_rdy, 1);
    chk("abort_no_frame", frames_done, f0);
    run_vec(5);

    // random regression
    f0 = frames_done;
    a0 = n_acc;
    cyc = 0;
    while (n_acc - a0 < 1000 && cyc < 40000) begin
      din     = DW'($urandom);
      din_vld = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    din_vld = 1'b0;
    chk("rand_timeout", (cyc < 40000), 1);
    repeat (FW + 4) step();
    chk("rand_frames", frames_done - f0, n_acc - a0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod3_frame_tx.md
# mod3_frame_tx

Serial frame transmitter paired with the team's serial mod-3 checker. It accepts a DW-bit parallel word over a valid/ready handshake and shifts it out MSB-first on a 1-bit line. It then appends a 2-bit check field so that every transmitted frame, read as a binary number, is divisible by 3. A downstream `mod3_check` sampling `dout` every cycle from reset raises `flag_y` after the last check bit of every frame.

## Interface
Parameters:
- `DW`, default 8: data word width in bits, legal range 2..32.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `din`, input, DW: parallel data word.
- `din_vld`, input, 1: `din` is valid.
- `din_rdy`, output, 1: block can accept a word this cycle.
- `dout`, output, 1: serial output bit, registered.
- `dout_vld`, output, 1: `dout` carries a frame bit, registered.
- `dout_first`, output, 1: current bit is the frame MSB, registered.
- `dout_last`, output, 1: current bit is the final check bit, registered.
- `busy`, output, 1: a frame is in progress (`dout_vld`).

## Operation
- Frame format is DW data bits (`din[DW-1]` first), then check bits `c[1]` then `c[0]`.
- The check value is c = (3 − (din mod 3)) mod 3, so it is 0, 1 or 2 and never 3.
- Frame value = din·4 + c, which is ≡ 0 mod 3.
- The residue is computed serially while shifting: res ← (2·res + bit) mod 3, in a 2-bit register cleared at frame accept. No divider is used.
- State machine:
  - IDLE → DATA on handshake (`din_vld & din_rdy`). On this transition, latch `din` into the shift register, load the bit counter with DW−1, and clear res.
  - DATA → DATA while count ≠ 0. Each cycle, shift one bit out, update res, and decrement the counter.
  - DATA → CHK0 after the data bit sent with count = 0. At this transition, latch c from the final updated residue.
  - CHK0 → CHK1 unconditionally.
  - CHK1 → IDLE unconditionally.
- `din_rdy` = 1 only in IDLE and not in reset. A word is accepted only when `din_vld & din_rdy`. `din` is ignored at all other times.
- Outside a frame, `dout` = 0 and `dout_vld` = 0. Driving 0 during idle keeps the cumulative stream value ≡ 0 mod 3 across gaps, so the downstream checker stays in phase.
- `dout_first` is asserted only with the first data bit. `dout_last` is asserted only with `c[0]`.
- Reset mid-frame aborts the frame:
  - On the next edge all outputs go to their reset values and the state goes to IDLE.
  - The partial frame is not completed. The downstream checker must also be reset.
- `din_vld` held high with no gap: frames are separated by exactly one idle cycle (the accept cycle).

## Timing
- Reset values:
  - `dout` = 0, `dout_vld` = 0, `dout_first` = 0, `dout_last` = 0, `busy` = 0.
  - `din_rdy` = 0 while `rst` = 1.
  - `din_rdy` = 1 in the first cycle after `rst` deasserts.
- Latency: a handshake at edge k puts the data MSB on `dout`, with `dout_vld` = 1 and `dout_first` = 1, in the cycle after edge k.
- Frame occupies DW+2 consecutive `dout_vld` cycles, with no bubbles.
- `dout_last` is high in cycle DW+2 of the frame. `din_rdy` rises in the cycle after `dout_last`.
- Throughput is one frame per DW+3 cycles.
- Flag alignment: the downstream `flag_y` rises one cycle after the `dout_last` cycle.

## Test plan
- DW=8, reset 2 cycles, then `din` = 8'h00: `dout` = 0000000000 (10 bits); `dout_last` on bit 10; checker flags.
- `din` = 8'h01 (residue 1): `dout` = 00000001 then 1, 0 (c = 2); frame value 6; checker flags after the last bit.
- `din` = 8'h05 (residue 2) then 8'hFF (residue 0), with `din_vld` held high:
  - First frame check bits are 01; second frame check bits are 00.
  - Exactly 1 idle cycle between frames with `dout` = 0; `din_rdy` pulses once per frame.
- `din` = 8'hA5 (residue 0, check bits 00), with `din_vld` dropped for 5 cycles after the handshake:
  - No second accept occurs.
  - Frame is 1010010100.
  - `dout` stays 0 with `dout_vld` = 0 in the gap.
- Reset asserted on the 4th data bit of frame 8'h3C: next cycle all outputs = 0 and `din_rdy` = 0. After release, `din_rdy` = 1, and a new frame 8'h02 transmits 00000010 then 0, 1.
- Random regression, 1000 words with random `din_vld` gaps: every frame has DW+2 bits, frame value mod 3 = 0, and the checker flags at every `dout_last`+1.
